// File: rtl/top_rd_burst_issuer.sv
// top_rd_burst_issuer: upstream control stage for a kernel read master.
// Splits a (byte address, byte size) command into AXI4 read bursts on the AR
// channel and counts bursts that are outstanding. It pulses ctrl_done once the
// read data path has reported every issued burst as complete.
// Optional build macro: TOP_RD_BURST_ISSUER_STALL_CNT_EN enables the
// saturating AR stall counter on stall_cycles. Without it the port reads 0.
module top_rd_burst_issuer #(
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_DATA_WIDTH       = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_MAX_BURST_LENGTH = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]       ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,
    output logic                          arvalid,
    input  logic                          arready,
    output logic [C_ADDR_WIDTH-1:0]       araddr,
    output logic [7:0]                    arlen,
    input  logic                          r_burst_done,
    output logic [31:0]                   stall_cycles
);

    localparam int BPB     = C_DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    // Beat counts carry one extra bit so that ceil(size/BPB) cannot overflow.
    localparam int BW      = C_XFER_SIZE_WIDTH + 1;
    localparam int OW      = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [BW-1:0]           ONE_BW       = BW'(1);
    localparam logic [BW-1:0]           BPB_M1_BW    = BW'(BPB - 1);
    localparam logic [BW-1:0]           MAX_BURST_BW = BW'(C_MAX_BURST_LENGTH);
    localparam logic [7:0]              MAX_LEN_M1   = 8'(C_MAX_BURST_LENGTH - 1);
    localparam logic [OW-1:0]           ONE_OW       = OW'(1);
    localparam logic [OW-1:0]           MAX_OUT_OW   = OW'(C_MAX_OUTSTANDING);
    localparam logic [C_ADDR_WIDTH-1:0] ONE_AW       = C_ADDR_WIDTH'(1);
    localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK   = ~C_ADDR_WIDTH'(BPB - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_arvalid;
    logic [C_ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]                r_arlen;
    logic                      r_busy;
    logic                      r_done;
    logic [BW-1:0]             r_remaining;
    logic [OW-1:0]             r_outstanding;

    logic                      w_hs;
    logic [BW-1:0]             w_burst_beats;
    logic [C_ADDR_WIDTH-1:0]   w_addr_step;
    logic [BW-1:0]             w_rem_after;
    logic                      w_out_inc;
    logic                      w_out_dec;
    logic [OW-1:0]             w_out_next;
    logic [BW-1:0]             w_total_beats;
    logic [C_ADDR_WIDTH-1:0]   w_start_addr;
    logic                      w_can_issue;

    // Burst length field (beats-1) for a given number of beats still to issue.
    function automatic logic [7:0] burst_len_m1(input logic [BW-1:0] beats);
        logic [7:0] len;
        if (beats >= MAX_BURST_BW) begin
            len = MAX_LEN_M1;
        end else begin
            len = 8'(beats - ONE_BW);
        end
        return len;
    endfunction

    // Handshake, next remaining/outstanding values and command decode.
    always_comb begin
        w_hs          = r_arvalid & arready;
        w_burst_beats = BW'(r_arlen) + ONE_BW;
        w_addr_step   = (C_ADDR_WIDTH'(r_arlen) + ONE_AW) << LOG_BPB;
        if (w_hs) begin
            w_rem_after = r_remaining - w_burst_beats;
        end else begin
            w_rem_after = r_remaining;
        end
        // A completion with nothing outstanding is dropped; a completion
        // coinciding with an issue cancels it out.
        w_out_inc = w_hs;
        w_out_dec = r_burst_done & ((r_outstanding != '0) | w_hs);
        case ({w_out_inc, w_out_dec})
            2'b10:   w_out_next = r_outstanding + ONE_OW;
            2'b01:   w_out_next = r_outstanding - ONE_OW;
            default: w_out_next = r_outstanding;
        endcase
        w_can_issue   = (w_rem_after != '0) && (w_out_next < MAX_OUT_OW);
        w_total_beats = ({1'b0, ctrl_xfer_size_in_bytes} + BPB_M1_BW) >> LOG_BPB;
        w_start_addr  = ctrl_addr_offset & ALIGN_MASK;
    end

    // Control FSM with all AR-channel and status outputs held in flops.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= 8'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_remaining   <= '0;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (ctrl_start) begin
                        r_araddr    <= w_start_addr;
                        r_remaining <= w_total_beats;
                        if (w_total_beats == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // Nothing can be outstanding in IDLE, so the
                            // first burst is offered straight away.
                            r_state   <= ST_ISSUE;
                            r_busy    <= 1'b1;
                            r_arvalid <= 1'b1;
                            r_arlen   <= burst_len_m1(w_total_beats);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_hs) begin
                        r_araddr    <= r_araddr + w_addr_step;
                        r_remaining <= w_rem_after;
                    end
                    if (r_arvalid && !arready) begin
                        // Offered burst is held stable until accepted.
                        r_arvalid <= 1'b1;
                    end else if (w_rem_after == '0) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_DRAIN;
                    end else begin
                        r_arvalid <= w_can_issue;
                        r_arlen   <= burst_len_m1(w_rem_after);
                    end
                end
                ST_DRAIN: begin
                    if (w_out_next == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_arvalid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign ctrl_busy = r_busy;
    assign ctrl_done = r_done;

`ifdef TOP_RD_BURST_ISSUER_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles an AR request waits on arready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_stall_cycles <= 32'd0;
        end else if ((r_state == ST_IDLE) && ctrl_start) begin
            r_stall_cycles <= 32'd0;
        end else if (r_arvalid && !arready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
